// File: rtl/phase_2b_pkg.sv
// phase_2b_pkg: shared phase/direction types and default width for the phase_2b rotate stage.
package phase_2b_pkg;
  typedef logic [1:0] phase_t;
  typedef enum logic {ROT_R = 1'b0, ROT_L = 1'b1} rot_dir_e;
  localparam int PHASE_2B_DEFAULT_W = 64;
endpackage

// File: rtl/phase_2b_rot.sv
// phase_2b_rot: combinational barrel rotator, two mux levels (by 1, then by 2), right or left.
module phase_2b_rot
  import phase_2b_pkg::*;
#(
  parameter int W = PHASE_2B_DEFAULT_W
) (
  input  logic [W-1:0] data,
  input  phase_t       amt,
  input  rot_dir_e     dir,
  output logic [W-1:0] result
);
  logic [W-1:0] w_s1;
  always_comb begin
    w_s1 = !amt[0] ? data
         : (dir == ROT_L) ? {data[W-2:0], data[W-1]} : {data[0], data[W-1:1]};
    result = !amt[1] ? w_s1
           : (dir == ROT_L) ? {w_s1[W-3:0], w_s1[W-1:W-2]} : {w_s1[1:0], w_s1[W-1:2]};
  end
endmodule

// File: rtl/phase_2b.sv
// phase_2b: registered rotate-by-k stage with valid/ready backpressure.
// Defining PHASE_2B_ROTL_EN adds a dir input selecting rotate-left.
module phase_2b
  import phase_2b_pkg::*;
#(
  parameter int BITSTREAM = PHASE_2B_DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           k,
`ifdef PHASE_2B_ROTL_EN
  input  logic                 dir,
`endif
  input  logic [BITSTREAM-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSTREAM-1:0] out_bits
);
  logic                 r_valid;
  logic [BITSTREAM-1:0] r_bits;
  logic [BITSTREAM-1:0] w_rot;
  rot_dir_e             w_dir;
`ifdef PHASE_2B_ROTL_EN
  assign w_dir = rot_dir_e'(dir);
`else
  assign w_dir = ROT_R;
`endif
  phase_2b_rot #(.W(BITSTREAM)) u_rot (
    .data  (in_bits),
    .amt   (phase_t'(k)),
    .dir   (w_dir),
    .result(w_rot)
  );
  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_bits  = r_bits;
  // Whenever the slot is free (empty or draining), valid simply follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_bits  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) r_bits <= w_rot;
    end
  end
endmodule

// File: tb/tb_phase_2b.sv
// tb_phase_2b: directed plus randomized checks of phase_2b against a per-bit index model.
module tb_phase_2b;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  k = 2'd0;
  logic        dir = 1'b0;
  logic [63:0] in_bits = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_bits;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  phase_2b #(.BITSTREAM(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .k        (k),
`ifdef PHASE_2B_ROTL_EN
    .dir      (dir),
`endif
    .in_bits  (in_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bits (out_bits)
  );

  function automatic logic [63:0] model(logic [63:0] d, int amt, bit left);
    logic [63:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = left ? d[(i - amt + 64) % 64] : d[(i + amt) % 64];
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [63:0] d, logic [1:0] kk);
    in_bits = d;
    k = kk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] a, b, w, held;
    in_valid = 1'b1;
    in_bits = 64'hDEAD_BEEF_0000_FFFF;
    repeat (3) tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_bits", out_bits, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    send(64'h1, 2'd1);
    chk("rot_k1", out_bits, 64'h8000_0000_0000_0000);
    chk("rot_k1_valid", 64'(out_valid), 64'd1);
    send(64'hF, 2'd3);
    chk("rot_k3", out_bits, 64'hE000_0000_0000_0001);
    send(64'h0123_4567_89AB_CDEF, 2'd2);
    chk("rot_k2", out_bits, 64'hC048_D159_E26A_F37B);
    send(64'h0123_4567_89AB_CDEF, 2'd0);
    chk("rot_k0", out_bits, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_hold_bits", out_bits, 64'h0123_4567_89AB_CDEF);

    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int n = 0; n < 101; n++) begin
      w = {$urandom, $urandom};
      in_bits = w;
      k = 2'(n % 4);
      tick();
      chk($sformatf("sweep_bits_%0d", n), out_bits, model(w, n % 4, 1'b0));
      chk($sformatf("sweep_valid_%0d", n), 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    tick();

    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    out_ready = 1'b0;
    send(a, 2'd1);
    held = model(a, 1, 1'b0);
    in_bits = b;
    k = 2'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_in_ready_%0d", c), 64'(in_ready), 64'd0);
      tick();
      chk($sformatf("stall_bits_%0d", c), out_bits, held);
      chk($sformatf("stall_valid_%0d", c), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("reload_bits", out_bits, model(b, 3, 1'b0));
    chk("reload_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_bits", out_bits, 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(64'h0000_0000_0000_0010, 2'd2);
    chk("post_rst_first_accept", out_bits, 64'h4);

`ifdef PHASE_2B_ROTL_EN
    dir = 1'b1;
    send(64'h8000_0000_0000_0000, 2'd1);
    chk("rotl_k1", out_bits, 64'h1);
    for (int n = 0; n < 8; n++) begin
      w = {$urandom, $urandom};
      dir = n[0];
      send(w, 2'(n % 4));
      chk($sformatf("rotl_rand_%0d", n), out_bits, model(w, n % 4, n[0]));
    end
    dir = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
